// File: rtl/z80_bus_sequencer.sv
// Z80 machine-cycle sequencer: one request in, registered T-state strobes out.
// Define Z80_BUS_REFRESH_EN to drive refresh (rfsh_n, R counter) in fetch T3/T4.
module z80_bus_sequencer #(
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int WR_T2    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cen,
    input  logic          req,
    input  logic [2:0]    req_type,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] A,
    output logic [DW-1:0] dout,
    output logic          m1_n,
    output logic          mreq_n,
    output logic          iorq_n,
    output logic          rd_n,
    output logic          wr_n,
    output logic          rfsh_n,
    input  logic          wait_n,
    input  logic [DW-1:0] di
);
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4} state_t;

    localparam logic [2:0] TY_FETCH = 3'd0;
    localparam logic [2:0] TY_MRD   = 3'd1;
    localparam logic [2:0] TY_MWR   = 3'd2;
    localparam logic [2:0] TY_IORD  = 3'd3;
    localparam logic [2:0] TY_IOWR  = 3'd4;
    localparam logic [2:0] TY_INTA  = 3'd5;

    state_t     state, state_nx;
    logic [2:0] typ, typ_nx;
    logic [3:0] cnt, cnt_nx;
    logic       accept;
    logic       m1_nx, mreq_nx, iorq_nx, rd_nx, wr_nx, rfsh_nx;
`ifdef Z80_BUS_REFRESH_EN
    logic [6:0] r;
`endif

    // Memory cycles use MEM_WAIT; I/O and intack add IO_WAIT to the built-in wait.
    function automatic logic [3:0] auto_wait(input logic [2:0] t);
        if (t <= TY_MWR) return 4'(MEM_WAIT);
        return 4'(IO_WAIT + 1);
    endfunction

    assign accept = (state == S_IDLE) && cen && req && (req_type <= TY_INTA);

    always_comb begin
        state_nx = state;
        typ_nx   = typ;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: if (accept) begin
                state_nx = S_T1;
                typ_nx   = req_type;
                cnt_nx   = auto_wait(req_type);
            end
            S_T1: if (cen) state_nx = S_T2;
            S_T2: if (cen) begin
                if (cnt != 4'd0 || !wait_n) begin
                    state_nx = S_TW;
                    if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = S_T3;
                end
            end
            S_TW: if (cen) begin
                if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
                else if (wait_n) state_nx = S_T3;
            end
            S_T3: if (cen) state_nx = (typ == TY_FETCH) ? S_T4 : S_IDLE;
            S_T4: if (cen) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobe levels are decoded from the state being entered, then registered.
    always_comb begin
        m1_nx   = 1'b1;
        mreq_nx = 1'b1;
        iorq_nx = 1'b1;
        rd_nx   = 1'b1;
        wr_nx   = 1'b1;
        rfsh_nx = 1'b1;
        case (state_nx)
            S_T1: m1_nx = !(typ_nx == TY_FETCH || typ_nx == TY_INTA);
            S_T2, S_TW: case (typ_nx)
                TY_FETCH: begin m1_nx = 1'b0; mreq_nx = 1'b0; rd_nx = 1'b0; end
                TY_MRD:   begin mreq_nx = 1'b0; rd_nx = 1'b0; end
                TY_MWR:   begin mreq_nx = 1'b0; wr_nx = (WR_T2 != 0) ? 1'b0 : 1'b1; end
                TY_IORD:  begin iorq_nx = 1'b0; rd_nx = 1'b0; end
                TY_IOWR:  begin iorq_nx = 1'b0; wr_nx = 1'b0; end
                TY_INTA:  begin m1_nx = 1'b0; iorq_nx = (state_nx != S_TW); end
                default:  ;
            endcase
            S_T3: case (typ_nx)
`ifdef Z80_BUS_REFRESH_EN
                TY_FETCH: begin mreq_nx = 1'b0; rfsh_nx = 1'b0; end
`endif
                TY_MRD:   begin mreq_nx = 1'b0; rd_nx = 1'b0; end
                TY_MWR:   begin mreq_nx = 1'b0; wr_nx = 1'b0; end
                TY_IORD:  begin iorq_nx = 1'b0; rd_nx = 1'b0; end
                TY_IOWR:  begin iorq_nx = 1'b0; wr_nx = 1'b0; end
                TY_INTA:  begin m1_nx = 1'b0; iorq_nx = 1'b0; end
                default:  ;
            endcase
`ifdef Z80_BUS_REFRESH_EN
            S_T4: rfsh_nx = 1'b0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            typ    <= 3'd0;
            cnt    <= 4'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rdata  <= '0;
            A      <= '0;
            dout   <= '0;
            m1_n   <= 1'b1;
            mreq_n <= 1'b1;
            iorq_n <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            rfsh_n <= 1'b1;
`ifdef Z80_BUS_REFRESH_EN
            r      <= 7'd0;
`endif
        end else begin
            state  <= state_nx;
            typ    <= typ_nx;
            cnt    <= cnt_nx;
            busy   <= (state_nx != S_IDLE);
            done   <= (state != S_IDLE) && (state_nx == S_IDLE);
            m1_n   <= m1_nx;
            mreq_n <= mreq_nx;
            iorq_n <= iorq_nx;
            rd_n   <= rd_nx;
            wr_n   <= wr_nx;
            rfsh_n <= rfsh_nx;
            if (accept) A <= req_addr;
            if (accept && (req_type == TY_MWR || req_type == TY_IOWR)) dout <= req_wdata;
            if ((state == S_T2 || state == S_TW) && state_nx == S_T3) rdata <= di;
`ifdef Z80_BUS_REFRESH_EN
            // Refresh address replaces the fetch address for T3/T4.
            if (state != S_T3 && state_nx == S_T3 && typ == TY_FETCH) A <= AW'({1'b0, r});
            if (state == S_T4 && cen) r <= r + 7'd1;
`endif
        end
    end
endmodule

// File: doc/z80_bus_sequencer.md
Name: z80_bus_sequencer

Overview:
Parametrised Z80 bus-cycle generator that replaces the fixed-timing synchronous strobe wrapper. A core-side request port supplies one machine cycle at a time: opcode fetch, memory read or write, I/O read or write, or interrupt acknowledge. The block sequences T-states and drives registered Z80 strobes, with configurable automatic wait states, external wait_n stretching, write-strobe timing and address/data widths. It sits between the CPU core and the system bus/memory decoders.

Parameters:
AW, 16, address width (>=8)
DW, 8, data width
MEM_WAIT, 0, automatic wait states on memory read/write/fetch (0-7)
IO_WAIT, 1, automatic wait states on I/O and interrupt acknowledge, added to the Z80 built-in one (0-7)
WR_T2, 1, 1 = memory wr_n asserted from T2; 0 = memory wr_n asserted in T3 only

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
cen  in  1  T-state enable; sequencer advances only on clk with cen=1
req  in  1  cycle request, sampled in IDLE on a cen clock
req_type  in  3  0 fetch, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 int ack; 6-7 ignored
req_addr  in  AW  cycle address
req_wdata  in  DW  write data
busy  out  1  cycle in progress
done  out  1  one-clk pulse, cycle complete
rdata  out  DW  latched read/vector data
A  out  AW  bus address
dout  out  DW  bus write data
m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  out  1 each  Z80 strobes, active low
wait_n  in  1  external wait, sampled on cen clocks in T2/TW
di  in  DW  bus read data

Behaviour:
- Reset (async, immediate, also mid-cycle): all _n outputs 1; A, dout, rdata 0; busy 0, done 0; FSM IDLE; R counter 0; in-flight cycle discarded, no done.
- FSM: IDLE, T1, T2, TW, T3, T4. All outputs registered and a function of the state entered. State frozen when cen=0; done still clears after one clk.
- Accept: IDLE, cen=1, req=1, req_type<=5 -> latch type/addr/wdata, enter T1, busy=1. req ignored while busy. Types 6-7 never accepted.
- Wait count: auto = MEM_WAIT for memory types, IO_WAIT+1 for io/intack. T2 -> TW while auto count remains or wait_n=0; TW -> T3 once auto count is exhausted and wait_n=1 on that cen clock.
- T1: A=addr; m1_n=0 for fetch/intack; dout=wdata for writes.
- T2/TW strobes:
  - fetch/mem rd: mreq_n=rd_n=0.
  - mem wr: mreq_n=0; wr_n=0 only if WR_T2=1.
  - io rd: iorq_n=rd_n=0.
  - io wr: iorq_n=wr_n=0.
  - intack: m1_n=0; iorq_n=0 in TW only.
- rdata <= di on the cen clock leaving T2/TW for T3.
- T3, non-fetch: strobes held as in T2, wr_n=0 for all writes. Exit T3 -> IDLE, done=1, busy=0.
- T3/T4, fetch: m1_n=rd_n=1, then refresh (see Optional Feature). Exit T4 -> IDLE, done=1.
- Zero-wait lengths in cen clocks: fetch 4, mem 3, io 4+IO_WAIT, intack 4+IO_WAIT.
- Back-to-back: req high in the done clock is accepted (FSM already IDLE); the next T1 immediately follows.
- Strobes are never low in IDLE; mreq_n and iorq_n are never simultaneously low.

Optional Feature:
Z80_BUS_REFRESH_EN.
- Defined: fetch T3/T4 drive rfsh_n=0 and A = zero-extended {R[6:0]} with bit 7 = 0. mreq_n=0 in T3 only. 7-bit R increments (wrapping 127->0) at each fetch completion.
- Undefined: rfsh_n constant 1; A holds fetch address in T3/T4; mreq_n=1 in T3/T4; no R counter.

Test Plan:
1. Defaults, cen=1, mem rd addr 0x1234, di=0xA5 -> mreq_n/rd_n low 2 clks, done at clk 3, rdata=0xA5, A=0x1234.
2. IO wr 0x00FE data 0x3C, IO_WAIT=1 -> iorq_n/wr_n low 4 clks, done after 5 clks, mreq_n stays 1.
3. Mem rd with wait_n=0 for 3 extra cen clocks, cen toggling 1/0 -> rdata sampled only after wait_n=1; cycle length 3+3 cen clocks; done 1 clk wide.
4. WR_T2=0 mem wr -> wr_n low only in T3. WR_T2=1 -> wr_n low in T2 and T3.
5. With Z80_BUS_REFRESH_EN, 130 fetches -> rfsh_n low in T3/T4, A[7:0] cycles 0..127 and wraps to 0,1. Without it, rfsh_n stays 1.
6. reset pulse in TW of intack -> all strobes 1 immediately, no done, busy=0; next req accepted normally.
